// File: rtl/persiana_multicanal.sv
// Multi-channel blind controller: shared command port, per-channel motor FSM with
// motion timeout fault and reversal dead-time, paced by an internal tick prescaler.
module persiana_multicanal #(
  parameter int NUM_CH        = 2,
  parameter int NUM_LEVELS    = 3,
  parameter int DIV           = 50_000_000,
  parameter int TIMEOUT_TICKS = 20,
  parameter int DEAD_TICKS    = 2,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LV_W = $clog2(NUM_LEVELS),
  localparam int PS_W = $clog2(DIV),
  localparam int MV_W = $clog2(TIMEOUT_TICKS + 1),
  localparam int DD_W = $clog2(DEAD_TICKS + 1)
) (
  input  logic                         clk,
  input  logic                         reseteo,
  input  logic                         cmd_valid,
  input  logic [CH_W-1:0]              cmd_ch,
  input  logic [1:0]                   cmd_op,
  input  logic [LV_W-1:0]              cmd_level,
  input  logic [1:0]                   luz,
  input  logic [NUM_CH*NUM_LEVELS-1:0] pos_sens,
  output logic                         cmd_ack,
  output logic                         cmd_err,
  output logic [NUM_CH-1:0]            subir,
  output logic [NUM_CH-1:0]            bajar,
  output logic [NUM_CH-1:0]            fault,
  output logic                         tick
);

  typedef enum logic [2:0] {ST_IDLE, ST_SUBIR, ST_BAJAR, ST_PAUSA, ST_FALLA} estado_t;

  logic [PS_W-1:0]        r_presc;
  logic                   r_tick;
  logic                   r_ack;
  logic                   r_err;
  logic                   w_ch_ok;
  logic                   w_lvl_ok;
  logic                   w_err;
  logic [(1<<CH_W)-1:0]   w_falla;
  logic [LV_W-1:0]        w_auto;

  always_ff @(posedge clk or posedge reseteo) begin
    if (reseteo) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (r_presc == PS_W'(DIV - 1)) begin
      r_presc <= '0;
      r_tick  <= 1'b1;
    end else begin
      r_presc <= r_presc + PS_W'(1);
      r_tick  <= 1'b0;
    end
  end

  assign w_ch_ok  = 32'(cmd_ch) < 32'(NUM_CH);
  assign w_lvl_ok = 32'(cmd_level) < 32'(NUM_LEVELS);
  // Go-to-level and auto are refused on a faulted channel; stop and clear are not.
  assign w_err    = !w_ch_ok || (cmd_op == 2'b00 && !w_lvl_ok) || (!cmd_op[1] && w_falla[cmd_ch]);
  assign w_auto   = LV_W'(((3 - int'(luz)) * (NUM_LEVELS - 1)) / 3);

  always_ff @(posedge clk or posedge reseteo) begin
    if (reseteo) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= cmd_valid && !w_err;
      r_err <= cmd_valid && w_err;
    end
  end

  assign cmd_ack = r_ack;
  assign cmd_err = r_err;
  assign tick    = r_tick;

  genvar gi;
  for (gi = NUM_CH; gi < (1 << CH_W); gi++) begin : g_pad
    assign w_falla[gi] = 1'b0;
  end

  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [NUM_LEVELS-1:0] w_sens;
    estado_t               r_state, w_state_n;
    logic                  r_mode, w_mode_n;
    logic [LV_W-1:0]       r_tgt, w_tgt_n, r_pos, w_pos;
    logic [MV_W-1:0]       r_move, w_move_n;
    logic [DD_W-1:0]       r_dead, w_dead_n;
    logic                  r_sub, r_baj, r_flt;
    logic                  w_hit;

    assign w_sens = pos_sens[gi*NUM_LEVELS +: NUM_LEVELS];
    assign w_hit  = cmd_valid && !w_err && (cmd_ch == CH_W'(gi));

    // Lowest set sensor wins; no sensor lit means the blind sits between two.
    always_comb begin
      w_pos = r_pos;
      for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
        if (w_sens[i]) w_pos = LV_W'(i);
      end
    end

    always_comb begin
      w_mode_n  = r_mode;
      w_tgt_n   = r_tgt;
      w_state_n = r_state;
      w_move_n  = r_move;
      w_dead_n  = r_dead;
      if (w_hit) begin
        case (cmd_op)
          2'b00:   begin w_tgt_n = cmd_level; w_mode_n = 1'b0; end
          2'b01:   w_mode_n = 1'b1;
          2'b10:   begin w_tgt_n = w_pos; w_mode_n = 1'b0; end
          default: ;
        endcase
      end
      if (r_tick && w_mode_n) w_tgt_n = w_auto;

      if (w_hit && cmd_op == 2'b10 && (r_state == ST_SUBIR || r_state == ST_BAJAR)) begin
        w_state_n = ST_PAUSA;
        w_dead_n  = '0;
      end else if (w_hit && cmd_op == 2'b11 && r_state == ST_FALLA) begin
        w_state_n = ST_IDLE;
      end else if (r_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (w_pos < w_tgt_n) begin
              w_state_n = ST_SUBIR;
              w_move_n  = '0;
            end else if (w_pos > w_tgt_n) begin
              w_state_n = ST_BAJAR;
              w_move_n  = '0;
            end
          end
          ST_SUBIR, ST_BAJAR: begin
            // A target on the far side means a reversal, which must pass through the dead-time.
            if ((r_state == ST_SUBIR) ? (w_tgt_n < w_pos) : (w_tgt_n > w_pos)) begin
              w_state_n = ST_PAUSA;
              w_dead_n  = '0;
            end else if (w_pos == w_tgt_n) begin
              w_state_n = ST_IDLE;
            end else if (r_move == MV_W'(TIMEOUT_TICKS - 1)) begin
              w_state_n = ST_FALLA;
            end else begin
              w_move_n = r_move + MV_W'(1);
            end
          end
          ST_PAUSA: begin
            if (r_dead == DD_W'(DEAD_TICKS - 1)) w_state_n = ST_IDLE;
            else w_dead_n = r_dead + DD_W'(1);
          end
          ST_FALLA: ;
          default:  w_state_n = ST_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or posedge reseteo) begin
      if (reseteo) begin
        r_state <= ST_IDLE;
        r_mode  <= 1'b0;
        r_tgt   <= '0;
        r_pos   <= '0;
        r_move  <= '0;
        r_dead  <= '0;
        r_sub   <= 1'b0;
        r_baj   <= 1'b0;
        r_flt   <= 1'b0;
      end else begin
        r_state <= w_state_n;
        r_mode  <= w_mode_n;
        r_tgt   <= w_tgt_n;
        r_pos   <= w_pos;
        r_move  <= w_move_n;
        r_dead  <= w_dead_n;
        r_sub   <= (w_state_n == ST_SUBIR);
        r_baj   <= (w_state_n == ST_BAJAR);
        r_flt   <= (w_state_n == ST_FALLA);
      end
    end

    assign subir[gi]   = r_sub;
    assign bajar[gi]   = r_baj;
    assign fault[gi]   = r_flt;
    assign w_falla[gi] = (r_state == ST_FALLA);
  end

endmodule

// File: tb/tb_persiana_multicanal.sv
// Directed bench for persiana_multicanal: two-channel instance for behaviour, plus a
// three-channel instance whose wider channel select can express an out-of-range channel.
module tb_persiana_multicanal;

  logic       clk = 1'b0;
  logic       reseteo = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ch = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [1:0] cmd_level = 2'b00;
  logic [1:0] luz = 2'b00;
  logic [5:0] pos_sens = 6'b001_001;
  logic       cmd_ack, cmd_err, tick;
  logic [1:0] subir, bajar, fault;

  logic       c3_cmd_valid = 1'b0;
  logic [1:0] c3_cmd_ch = 2'b00;
  logic [1:0] c3_cmd_op = 2'b11;
  logic [1:0] c3_cmd_level = 2'b00;
  logic [8:0] c3_pos_sens = 9'b001_001_001;
  logic       c3_ack, c3_err, c3_tick;
  logic [2:0] c3_subir, c3_bajar, c3_fault;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  persiana_multicanal #(
    .NUM_CH(2), .NUM_LEVELS(3), .DIV(4), .TIMEOUT_TICKS(8), .DEAD_TICKS(2)
  ) u_dut (
    .clk(clk), .reseteo(reseteo), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch),
    .cmd_op(cmd_op), .cmd_level(cmd_level), .luz(luz), .pos_sens(pos_sens),
    .cmd_ack(cmd_ack), .cmd_err(cmd_err), .subir(subir), .bajar(bajar),
    .fault(fault), .tick(tick)
  );

  persiana_multicanal #(
    .NUM_CH(3), .NUM_LEVELS(3), .DIV(4), .TIMEOUT_TICKS(8), .DEAD_TICKS(2)
  ) u_dut3 (
    .clk(clk), .reseteo(reseteo), .cmd_valid(c3_cmd_valid), .cmd_ch(c3_cmd_ch),
    .cmd_op(c3_cmd_op), .cmd_level(c3_cmd_level), .luz(luz), .pos_sens(c3_pos_sens),
    .cmd_ack(c3_ack), .cmd_err(c3_err), .subir(c3_subir), .bajar(c3_bajar),
    .fault(c3_fault), .tick(c3_tick)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns one cycle after the FSMs have evaluated the next (or current) tick.
  task automatic wait_tick();
    int n = 0;
    while (!tick && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (!tick) check("tick_timeout", 8'(tick), 8'd1);
    @(negedge clk);
  endtask

  // Keeps the command strobe off tick cycles so tick counting stays unambiguous.
  task automatic send_cmd(input logic ch, input logic [1:0] op, input logic [1:0] lvl);
    @(negedge clk);
    if (tick) @(negedge clk);
    cmd_ch    = ch;
    cmd_op    = op;
    cmd_level = lvl;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  always @(negedge clk) begin
    if (!reseteo && (subir | bajar) != 2'b00) begin
      n_checks++;
      assert ((subir & bajar) === 2'b00) else begin
        n_errors++;
        $error("FAIL both_motor_dirs: observed subir=%b bajar=%b expected no overlap", subir, bajar);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_subir", 8'(subir), 8'd0);
    check("rst_bajar", 8'(bajar), 8'd0);
    check("rst_fault", 8'(fault), 8'd0);
    check("rst_ack", 8'(cmd_ack), 8'd0);
    check("rst_err", 8'(cmd_err), 8'd0);
    check("rst_tick", 8'(tick), 8'd0);
    reseteo = 1'b0;

    // Prescaler: first tick after the 4th clock following release.
    repeat (3) @(negedge clk);
    check("presc_not_yet", 8'(tick), 8'd0);
    @(negedge clk);
    check("presc_first", 8'(tick), 8'd1);
    @(negedge clk);
    check("presc_one_cycle", 8'(tick), 8'd0);

    // 1: go up to the top level, stop when the top sensor lights.
    send_cmd(1'b0, 2'b00, 2'd2);
    check("t1_ack", 8'(cmd_ack), 8'd1);
    check("t1_err", 8'(cmd_err), 8'd0);
    wait_tick();
    check("t1_subir", 8'(subir), 8'b01);
    check("t1_bajar", 8'(bajar), 8'b00);
    pos_sens = 6'b001_100;
    wait_tick();
    check("t1_arrived", 8'(subir), 8'b00);

    // 2: reversal while moving up must pass through two dead ticks.
    pos_sens = 6'b001_010;
    wait_tick();
    check("t2_moving_up", 8'(subir), 8'b01);
    send_cmd(1'b0, 2'b00, 2'd0);
    check("t2_ack", 8'(cmd_ack), 8'd1);
    wait_tick();
    check("t2_dead0", 8'({subir, bajar}), 8'd0);
    wait_tick();
    check("t2_dead1", 8'({subir, bajar}), 8'd0);
    wait_tick();
    check("t2_dead2", 8'({subir, bajar}), 8'd0);
    wait_tick();
    check("t2_bajar", 8'(bajar), 8'b01);
    check("t2_subir", 8'(subir), 8'b00);

    // 6: stop while moving down: immediate pause, then rest with target = current position.
    send_cmd(1'b0, 2'b10, 2'd0);
    check("t6_ack", 8'(cmd_ack), 8'd1);
    check("t6_bajar_drop", 8'(bajar), 8'b00);
    wait_ticks(4);
    check("t6_rest", 8'({subir, bajar}), 8'd0);

    // 3: target unreachable -> timeout fault after 8 ticks of motion.
    send_cmd(1'b0, 2'b00, 2'd2);
    pos_sens = 6'b001_001;
    wait_tick();
    check("t3_start", 8'(subir), 8'b01);
    wait_ticks(7);
    check("t3_still_moving", 8'(subir), 8'b01);
    check("t3_no_fault_yet", 8'(fault), 8'b00);
    wait_tick();
    check("t3_fault", 8'(fault), 8'b01);
    check("t3_motor_off", 8'({subir, bajar}), 8'd0);
    send_cmd(1'b0, 2'b00, 2'd1);
    check("t3_goto_err", 8'(cmd_err), 8'd1);
    check("t3_goto_noack", 8'(cmd_ack), 8'd0);
    send_cmd(1'b0, 2'b01, 2'd0);
    check("t3_auto_err", 8'(cmd_err), 8'd1);
    send_cmd(1'b0, 2'b11, 2'd0);
    check("t3_clear_ack", 8'(cmd_ack), 8'd1);
    check("t3_fault_clr", 8'(fault), 8'b00);
    send_cmd(1'b0, 2'b10, 2'd0);
    check("t3_stop_ack", 8'(cmd_ack), 8'd1);

    // 4: out-of-range level refused, channel left alone.
    send_cmd(1'b1, 2'b00, 2'd3);
    check("t4_lvl_err", 8'(cmd_err), 8'd1);
    check("t4_lvl_noack", 8'(cmd_ack), 8'd0);
    wait_ticks(3);
    check("t4_no_motion", 8'({subir, bajar}), 8'd0);

    // 5: auto mode follows the light sensor.
    luz = 2'd3;
    send_cmd(1'b1, 2'b01, 2'd0);
    check("t5_auto_ack", 8'(cmd_ack), 8'd1);
    wait_ticks(2);
    check("t5_bright_idle", 8'({subir, bajar}), 8'd0);
    luz = 2'd0;
    wait_tick();
    check("t5_dark_up", 8'(subir), 8'b10);

    // Reset mid-motion drops outputs without waiting for a clock edge.
    @(negedge clk);
    #1 reseteo = 1'b1;
    #1;
    check("rst_async_subir", 8'(subir), 8'd0);
    check("rst_async_bajar", 8'(bajar), 8'd0);
    @(negedge clk);
    reseteo = 1'b0;

    // Contradictory sensors (lowest wins), then no sensor lit keeps the last position.
    pos_sens = 6'b001_110;
    send_cmd(1'b0, 2'b00, 2'd1);
    check("multi_ack", 8'(cmd_ack), 8'd1);
    wait_ticks(2);
    check("multi_lowest", 8'({subir, bajar}), 8'd0);
    pos_sens = 6'b001_000;
    wait_ticks(2);
    check("between_hold", 8'({subir, bajar}), 8'd0);
    send_cmd(1'b0, 2'b00, 2'd0);
    wait_tick();
    check("between_down", 8'(bajar), 8'b01);

    // Channel range guard on the three-channel instance.
    @(negedge clk);
    c3_cmd_ch = 2'd3;
    c3_cmd_op = 2'b11;
    c3_cmd_valid = 1'b1;
    @(negedge clk);
    c3_cmd_valid = 1'b0;
    check("c3_ch3_err", 8'(c3_err), 8'd1);
    check("c3_ch3_noack", 8'(c3_ack), 8'd0);
    @(negedge clk);
    c3_cmd_ch = 2'd2;
    c3_cmd_valid = 1'b1;
    @(negedge clk);
    c3_cmd_valid = 1'b0;
    check("c3_ch2_ack", 8'(c3_ack), 8'd1);
    check("c3_ch2_noerr", 8'(c3_err), 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
